// File: rtl/tx_status_stat.sv
// tx_status_stat: drains packed tx status words from a FWFT FIFO,
// keeps per-queue ok/fail/retry statistics and raises a coalesced irq.
module tx_status_stat #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic             enable,
   input  logic             clear,
   input  logic [6:0]       irq_thresh,
   input  logic             irq_ack,
   input  logic [3:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_out,
   output logic [31:0]      last_word,
   output logic [9:0]       last_sn,
   output logic             irq
);

   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      POP,
      UPD
   } state_e;

   state_e state_q, state_d;

   logic [31:0]      word_q;
   logic [CNT_W-1:0] ok_q    [4];
   logic [CNT_W-1:0] fail_q  [4];
   logic [CNT_W-1:0] retry_q [4];
   logic [CNT_W-1:0] ok_d    [4];
   logic [CNT_W-1:0] fail_d  [4];
   logic [CNT_W-1:0] retry_d [4];
   logic [6:0]       pend_q, pend_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             upd;
   logic [1:0]       qi;
   logic             acked;
   logic [CNT_W:0]   rsum;
   logic             irq_set;

   assign upd   = (state_q == UPD);
   assign qi    = word_q[16:15];
   assign acked = word_q[4];
   assign rsum  = {1'b0, retry_q[qi]} + (CNT_W+1)'(word_q[3:0]);

   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      unique case (state_q)
         IDLE: if (enable && !fifo_empty) state_d = POP;
         POP: begin
            fifo_rd_en = 1'b1;
            state_d    = UPD;
         end
         UPD:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // clear beats a coincident update; the raw word still reaches last_word
   always_comb begin
      ok_d    = ok_q;
      fail_d  = fail_q;
      retry_d = retry_q;
      if (clear) begin
         for (int i = 0; i < 4; i++) begin
            ok_d[i]    = '0;
            fail_d[i]  = '0;
            retry_d[i] = '0;
         end
      end else if (upd) begin
         if (acked) begin
            if (!(&ok_q[qi])) ok_d[qi] = ok_q[qi] + CNT_W'(1);
         end else begin
            if (!(&fail_q[qi])) fail_d[qi] = fail_q[qi] + CNT_W'(1);
         end
         retry_d[qi] = rsum[CNT_W] ? '1 : rsum[CNT_W-1:0];
      end
   end

   always_comb begin
      pend_d = pend_q;
      if (clear) pend_d = '0;
      else if (irq_ack) pend_d = upd ? 7'd1 : 7'd0;
      else if (upd && pend_q != 7'd127) pend_d = pend_q + 7'd1;
   end

   always_comb begin
      tmr_d = tmr_q;
      if (clear || irq_ack || upd || pend_q == 7'd0) tmr_d = '0;
      else if (tmr_q != TMAX) tmr_d = tmr_q + TW'(1);
   end

   assign irq_set = ((irq_thresh != 7'd0) && (pend_q >= irq_thresh)) ||
                    ((pend_q != 7'd0) && (tmr_q == TMAX));

   always_comb begin
      irq_d = irq_q | irq_set;
      if (clear || irq_ack) irq_d = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      unique case (cnt_sel[1:0])
         2'd0:    cnt_d = ok_q[cnt_sel[3:2]];
         2'd1:    cnt_d = fail_q[cnt_sel[3:2]];
         2'd2:    cnt_d = retry_q[cnt_sel[3:2]];
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         word_q    <= '0;
         pend_q    <= '0;
         tmr_q     <= '0;
         irq_q     <= 1'b0;
         cnt_q     <= '0;
         last_word <= '0;
         last_sn   <= '0;
         for (int i = 0; i < 4; i++) begin
            ok_q[i]    <= '0;
            fail_q[i]  <= '0;
            retry_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         tmr_q   <= tmr_d;
         irq_q   <= irq_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
         retry_q <= retry_d;
         if (state_q == POP) word_q <= fifo_dout;
         if (upd) begin
            last_word <= word_q;
            last_sn   <= word_q[14:5];
         end
      end
   end

   assign cnt_out = cnt_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_tx_status_stat.sv
// Bench for tx_status_stat: FIFO model, per-queue reference counters,
// one full-width and one 4-bit-counter instance driven in lockstep.
module tb_tx_status_stat;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        rd_en, rd_en_s;
   logic        enable, clear, irq_ack;
   logic [6:0]  irq_thresh;
   logic [3:0]  cnt_sel;
   logic [31:0] cnt_out;
   logic [3:0]  cnt_out_s;
   logic [31:0] last_word, last_word_s;
   logic [9:0]  last_sn, last_sn_s;
   logic        irq, irq_s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] fq[$];
   int          pop_log[$];
   bit          prev_rd = 1'b0;
   bit          killed = 1'b0;
   longint      ok_m[4];
   longint      fail_m[4];
   longint      retry_m[4];

   tx_status_stat #(.CNT_W(32), .TIMEOUT_CYC(16)) u_dut (
      .clk(clk), .rstn(rstn),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en), .enable(enable), .clear(clear),
      .irq_thresh(irq_thresh), .irq_ack(irq_ack),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out),
      .last_word(last_word), .last_sn(last_sn), .irq(irq)
   );

   tx_status_stat #(.CNT_W(4), .TIMEOUT_CYC(16)) u_sat (
      .clk(clk), .rstn(rstn),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en_s), .enable(enable), .clear(clear),
      .irq_thresh(irq_thresh), .irq_ack(irq_ack),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out_s),
      .last_word(last_word_s), .last_sn(last_sn_s), .irq(irq_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat(input longint v, input int w);
      longint m;
      m = (64'sd1 <<< w) - 1;
      if (v > m) return 32'(m);
      return 32'(v);
   endfunction

   function automatic void model_zero();
      for (int i = 0; i < 4; i++) begin
         ok_m[i] = 0;
         fail_m[i] = 0;
         retry_m[i] = 0;
      end
   endfunction

   function automatic void model_apply(input logic [31:0] w);
      int q;
      q = int'(w[16:15]);
      if (w[4]) ok_m[q]++;
      else fail_m[q]++;
      retry_m[q] += longint'(w[3:0]);
   endfunction

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_dout = fifo_empty ? 32'h5A5A_5A5A : fq[0];
   endtask

   task automatic push(input logic [31:0] w);
      fq.push_back(w);
      refresh();
   endtask

   task automatic step(input bit kill);
      bit popped;
      logic [31:0] w;
      @(negedge clk);
      chk("rd_en lockstep", 32'(rd_en_s), 32'(rd_en));
      chk("irq lockstep", 32'(irq_s), 32'(irq));
      if (rd_en) begin
         chk("pop while empty", 32'(fifo_empty), 32'd0);
         chk("pop back-to-back", 32'(prev_rd), 32'd0);
         pop_log.push_back(cyc);
      end
      popped = rd_en;
      prev_rd = rd_en;
      if (kill && rd_en) begin
         rstn = 1'b0;
         killed = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (popped && fq.size() != 0) begin
         w = fq.pop_front();
         model_apply(w);
      end
      refresh();
   endtask

   task automatic wait_pops(input int target, input string tag);
      int n;
      n = 0;
      while (pop_log.size() < target && n < 40) begin
         step(0);
         n++;
      end
      chk(tag, pop_log.size(), target);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (fq.size() != 0 && n < 400) begin
         step(0);
         n++;
      end
      chk("drain", fq.size(), 0);
      repeat (3) step(0);
   endtask

   task automatic rd_chk(input int q, input int k);
      longint e;
      cnt_sel = 4'(q * 4 + k);
      step(0);
      e = (k == 0) ? ok_m[q] : (k == 1) ? fail_m[q] :
          (k == 2) ? retry_m[q] : 64'sd0;
      chk($sformatf("cnt q%0d k%0d", q, k), cnt_out, sat(e, 32));
      chk($sformatf("cnt4 q%0d k%0d", q, k), 32'(cnt_out_s), sat(e, 4));
   endtask

   task automatic check_all();
      for (int q = 0; q < 4; q++)
         for (int k = 0; k < 4; k++)
            rd_chk(q, k);
   endtask

   task automatic ack_pulse();
      irq_ack = 1'b1;
      step(0);
      irq_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      rstn = 1'b0;
      enable = 1'b0;
      clear = 1'b0;
      irq_ack = 1'b0;
      irq_thresh = 7'd0;
      cnt_sel = 4'd0;
      model_zero();
      refresh();
      repeat (3) step(0);
      chk("rst rd_en", 32'(rd_en), 32'd0);
      chk("rst irq", 32'(irq), 32'd0);
      chk("rst cnt_out", cnt_out, 32'd0);
      chk("rst last_word", last_word, 32'd0);
      chk("rst last_sn", 32'(last_sn), 32'd0);
      rstn = 1'b1;
      step(0);

      // single acked entry on queue 1, threshold 1
      irq_thresh = 7'd1;
      enable = 1'b1;
      pop_log.delete();
      push(32'h0000_8013);
      wait_pops(1, "t1 pop");
      step(0);
      chk("t1 irq early", 32'(irq), 32'd0);
      step(0);
      chk("t1 irq", 32'(irq), 32'd1);
      chk("t1 last_sn", 32'(last_sn), 32'd0);
      chk("t1 last_word", last_word, 32'h0000_8013);
      check_all();
      ack_pulse();
      chk("t1 ack", 32'(irq), 32'd0);
      repeat (5) step(0);
      chk("t1 pending cleared", 32'(irq), 32'd0);

      // ten failed entries on queue 2, status 0x0F
      irq_thresh = 7'd0;
      pop_log.delete();
      for (int i = 0; i < 10; i++) begin
         w = ($urandom & 32'hFFFE_7FE0) | 32'h0001_0000 | 32'h0F;
         push(w);
      end
      drain();
      chk("t2 pops", pop_log.size(), 10);
      for (int i = 1; i < pop_log.size(); i++)
         chk("t2 spacing", pop_log[i] - pop_log[i-1], 3);
      chk("t2 last_word", last_word, w);
      chk("t2 last_sn", 32'(last_sn), 32'(w[14:5]));
      ack_pulse();
      check_all();

      // random words with enable toggling
      push(32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++) push($urandom);
      begin
         int n;
         n = 0;
         while (fq.size() != 0 && n < 400) begin
            enable = 1'($urandom % 2);
            step(0);
            n++;
         end
      end
      enable = 1'b1;
      drain();
      check_all();
      ack_pulse();

      // timeout irq with threshold disabled
      clear = 1'b1;
      step(0);
      clear = 1'b0;
      model_zero();
      irq_thresh = 7'd0;
      pop_log.delete();
      push($urandom);
      wait_pops(1, "t4 pop");
      repeat (16) step(0);
      chk("t4 irq before timeout", 32'(irq), 32'd0);
      step(0);
      chk("t4 irq timeout", 32'(irq), 32'd1);
      ack_pulse();
      chk("t4 ack", 32'(irq), 32'd0);
      repeat (20) step(0);
      chk("t4 pending zero", 32'(irq), 32'd0);

      // ack coincident with UPD of the second entry
      irq_thresh = 7'd1;
      pop_log.delete();
      push($urandom);
      push($urandom);
      wait_pops(2, "t5 pops");
      irq_ack = 1'b1;
      step(0);
      irq_ack = 1'b0;
      chk("t5 irq acked", 32'(irq), 32'd0);
      step(0);
      chk("t5 irq reassert", 32'(irq), 32'd1);
      ack_pulse();
      drain();
      check_all();

      // clear coincident with UPD
      pop_log.delete();
      w = $urandom;
      push(w);
      wait_pops(1, "t6 pop");
      clear = 1'b1;
      step(0);
      clear = 1'b0;
      model_zero();
      chk("t6 last_word", last_word, w);
      repeat (4) step(0);
      chk("t6 irq", 32'(irq), 32'd0);
      check_all();

      // reset during POP loses the word
      killed = 1'b0;
      push($urandom);
      begin
         int n;
         n = 0;
         while (!killed && n < 20) begin
            step(1);
            n++;
         end
      end
      chk("t7 killed in POP", 32'(killed), 32'd1);
      step(0);
      rstn = 1'b1;
      model_zero();
      chk("t7 fifo consumed", fq.size(), 0);
      chk("t7 rd_en idle", 32'(rd_en), 32'd0);
      chk("t7 irq", 32'(irq), 32'd0);
      check_all();

      // saturation of the 4-bit instance
      irq_thresh = 7'd0;
      for (int i = 0; i < 20; i++) begin
         w = ($urandom & 32'hFFFE_7FE0) | 32'h10 | 32'(8 + $urandom % 8);
         push(w);
      end
      drain();
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
